// File: rtl/alu_mc_if.sv
// Handshake and operand bundle for the multi-cycle picoMIPS ALU.
// master drives start/func/selects/operands; slave returns busy/done/result/flags.
interface alu_mc_if #(
  parameter int N = 8
);
  logic         start;
  logic [2:0]   func;
  logic [1:0]   a_sel;
  logic [1:0]   b_sel;
  logic [N-1:0] a_in;
  logic [N-1:0] b_in;
  logic [N:0]   switches;
  logic [N-1:0] immediate;
  logic         busy;
  logic         done;
  logic [N-1:0] result;
  logic [3:0]   flags;

  modport master (
    output start, func, a_sel, b_sel,
    output a_in, b_in, switches, immediate,
    input  busy, done, result, flags
  );

  modport slave (
    input  start, func, a_sel, b_sel,
    input  a_in, b_in, switches, immediate,
    output busy, done, result, flags
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle N-bit ALU: RA/RB/ADD/SUB in one clock, shift-add MULL/MULH in N.
// Ports: clk, nreset (async, active-low), bus (alu_mc_if.slave); flags = {V,N,Z,C}.
module alu_mc #(
  parameter int N = 8
) (
  input  logic    clk,
  input  logic    nreset,
  alu_mc_if.slave bus
);
  localparam int CW = $clog2(N);

  typedef enum logic {IDLE, MUL} state_t;

  state_t         state;
  state_t         state_n;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] p;
  logic [2*N-1:0] p_n;
  logic [2*N-1:0] p_acc;
  logic [N-1:0]   a_r;
  logic           mulh_r;
  logic [N-1:0]   a_m;
  logic [N-1:0]   b_m;
  logic           is_mul;
  logic           accept;
  logic           fin;
  logic [N:0]     sum;
  logic [N:0]     dif;
  logic [N-1:0]   alu_res;
  logic [3:0]     alu_flg;
  logic           v;
  logic           c;
  logic [N-1:0]   mul_res;
  logic [3:0]     mul_flg;

  function automatic logic [2*N-1:0] step(
    input logic [2*N-1:0] pp,
    input logic [N-1:0]   aa
  );
    logic [N:0] hi;
    hi = {1'b0, pp[2*N-1:N]} + (pp[0] ? {1'b0, aa} : '0);
    return {hi, pp[N-1:1]};
  endfunction

  always_comb begin
    case (bus.a_sel)
      2'd1:    a_m = bus.switches[N-1:0];
      2'd2:    a_m = {N{bus.switches[N]}};
      default: a_m = bus.a_in;
    endcase
    case (bus.b_sel)
      2'd1:    b_m = bus.switches[N-1:0];
      2'd2:    b_m = {N{bus.switches[N]}};
      2'd3:    b_m = bus.immediate;
      default: b_m = bus.b_in;
    endcase
  end

  assign is_mul = (bus.func == 3'd4) || (bus.func == 3'd5);

  always_comb begin
    sum     = {1'b0, a_m} + {1'b0, b_m};
    dif     = {1'b0, a_m} - {1'b0, b_m};
    alu_res = a_m;
    v       = 1'b0;
    c       = 1'b0;
    unique case (1'b1)
      (bus.func == 3'd1): alu_res = b_m;
      (bus.func == 3'd2): begin
        alu_res = sum[N-1:0];
        c = sum[N];
        v = (a_m[N-1] == b_m[N-1]) &&
            (sum[N-1] != a_m[N-1]);
      end
      (bus.func == 3'd3): begin
        alu_res = dif[N-1:0];
        c = dif[N];
        v = (a_m[N-1] != b_m[N-1]) &&
            (dif[N-1] != a_m[N-1]);
      end
      default: ;
    endcase
    alu_flg = {v, alu_res[N-1], alu_res == '0, c};
  end

  // The accept edge already performs the first iteration,
  // so only N-1 MUL cycles follow and busy lasts N-1 clocks.
  assign p_acc = step({{N{1'b0}}, b_m}, a_m);
  assign p_n   = step(p, a_r);

  always_comb begin
    mul_res = mulh_r ? p_n[2*N-1:N] : p_n[N-1:0];
    mul_flg = {~mulh_r && (p_n[2*N-1:N] != '0),
               mul_res[N-1], mul_res == '0, 1'b0};
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n  = state;
    accept   = 1'b0;
    fin      = 1'b0;
    bus.busy = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept = 1'b1;
          if (is_mul) state_n = MUL;
        end
      end
      MUL: begin
        bus.busy = 1'b1;
        if (cnt == CW'(N-1)) begin
          fin     = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      p          <= '0;
      cnt        <= '0;
      a_r        <= '0;
      mulh_r     <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.flags  <= '0;
    end else begin
      bus.done <= (accept && !is_mul) || fin;
      if (accept) begin
        a_r    <= a_m;
        mulh_r <= bus.func[0];
      end
      if (accept && is_mul) begin
        p   <= p_acc;
        cnt <= CW'(1);
      end else if (state == MUL) begin
        p   <= p_n;
        cnt <= fin ? '0 : cnt + 1'b1;
      end
      if (accept && !is_mul) begin
        bus.result <= alu_res;
        bus.flags  <= alu_flg;
      end else if (fin) begin
        bus.result <= mul_res;
        bus.flags  <= mul_flg;
      end
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Randomised and directed bench for alu_mc (N=8).
// Reference model tracks busy/done/result/flags from arithmetic rules.
module tb_alu_mc;
  localparam int N = 8;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  bit   check_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_mc_if #(.N(N)) bus ();

  alu_mc #(.N(N)) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit         m_pend = 0;
  bit         m_done = 0;
  int         m_left = 0;
  logic [7:0] m_res = '0;
  logic [3:0] m_flags = '0;
  logic [7:0] p_res;
  logic [3:0] p_flags;

  function automatic logic [7:0] sel_a(input logic [1:0] s,
                                       input logic [7:0] ain,
                                       input logic [8:0] sw);
    if (s == 2'd1) return sw[7:0];
    if (s == 2'd2) return sw[8] ? 8'hFF : 8'h00;
    return ain;
  endfunction

  function automatic logic [7:0] sel_b(input logic [1:0] s,
                                       input logic [7:0] bin,
                                       input logic [8:0] sw,
                                       input logic [7:0] imm);
    if (s == 2'd1) return sw[7:0];
    if (s == 2'd2) return sw[8] ? 8'hFF : 8'h00;
    if (s == 2'd3) return imm;
    return bin;
  endfunction

  function automatic void ref_op(input logic [2:0] f,
                                 input logic [7:0] a,
                                 input logic [7:0] b,
                                 output logic [7:0] r,
                                 output logic [3:0] fl,
                                 output bit mul);
    logic [31:0] ua, ub, s;
    int sa, sb, si;
    logic v, c;
    ua = 32'(a);
    ub = 32'(b);
    sa = $signed(a);
    sb = $signed(b);
    v = 1'b0;
    c = 1'b0;
    mul = 0;
    s = ua * ub;
    case (f)
      3'd1: r = b;
      3'd2: begin
        s = ua + ub;
        r = s[7:0];
        c = (s > 255);
        si = sa + sb;
        v = (si > 127) || (si < -128);
      end
      3'd3: begin
        s = ua - ub;
        r = s[7:0];
        c = (ua < ub);
        si = sa - sb;
        v = (si > 127) || (si < -128);
      end
      3'd4: begin
        r = s[7:0];
        v = (s > 255);
        mul = 1;
      end
      3'd5: begin
        r = s[15:8];
        mul = 1;
      end
      default: r = a;
    endcase
    fl = {v, r[7], r == 8'h00, c};
  endfunction

  always @(posedge clk or negedge nreset) begin
    logic [7:0] r;
    logic [3:0] fl;
    bit mul;
    if (!nreset) begin
      m_pend = 0;
      m_done = 0;
      m_left = 0;
      m_res = '0;
      m_flags = '0;
    end else begin
      m_done = 0;
      if (m_pend) begin
        m_left--;
        if (m_left == 0) begin
          m_pend = 0;
          m_res = p_res;
          m_flags = p_flags;
          m_done = 1;
        end
      end else if (bus.start) begin
        ref_op(bus.func,
               sel_a(bus.a_sel, bus.a_in, bus.switches),
               sel_b(bus.b_sel, bus.b_in, bus.switches, bus.immediate),
               r, fl, mul);
        if (mul) begin
          m_pend = 1;
          m_left = N - 1;
          p_res = r;
          p_flags = fl;
        end else begin
          m_res = r;
          m_flags = fl;
          m_done = 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (check_en) begin
      n_cmp++;
      if ({bus.busy, bus.done, bus.result, bus.flags} !==
          {m_pend, m_done, m_res, m_flags}) begin
        n_bad++;
        $display("FAIL cycle t=%0t busy/done/result/flags got %b/%b/%h/%h want %b/%b/%h/%h",
                 $time, bus.busy, bus.done, bus.result, bus.flags,
                 m_pend, m_done, m_res, m_flags);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f, input logic [1:0] as,
                       input logic [1:0] bs, input logic [7:0] a,
                       input logic [7:0] b, input logic [8:0] sw,
                       input logic [7:0] imm);
    bus.func = f;
    bus.a_sel = as;
    bus.b_sel = bs;
    bus.a_in = a;
    bus.b_in = b;
    bus.switches = sw;
    bus.immediate = imm;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic wait_done(input int exp_lat, input logic [7:0] er,
                           input logic [3:0] ef, input string nm);
    int lat = 0;
    bit got = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.done === 1'b1) got = 1;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout got no done want done", nm);
    end else begin
      chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
      chk({nm, " result"}, 32'(bus.result), 32'(er));
      chk({nm, " flags"}, 32'(bus.flags), 32'(ef));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.start = 0;
    bus.func = 0;
    bus.a_sel = 0;
    bus.b_sel = 0;
    bus.a_in = 0;
    bus.b_in = 0;
    bus.switches = 0;
    bus.immediate = 0;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(bus.busy), 0);
    chk("reset done", 32'(bus.done), 0);
    chk("reset result", 32'(bus.result), 0);
    chk("reset flags", 32'(bus.flags), 0);
    nreset = 1'b1;
    check_en = 1'b1;

    issue(3'd2, 2'd0, 2'd0, 8'h7F, 8'h01, 9'h0, 8'h0);
    wait_done(1, 8'h80, 4'b1100, "add 7f+01");
    issue(3'd2, 2'd0, 2'd0, 8'hFF, 8'h01, 9'h0, 8'h0);
    wait_done(1, 8'h00, 4'b0011, "add ff+01");
    issue(3'd3, 2'd0, 2'd0, 8'h00, 8'h01, 9'h0, 8'h0);
    wait_done(1, 8'hFF, 4'b0101, "sub 00-01");
    issue(3'd3, 2'd0, 2'd0, 8'h05, 8'h05, 9'h0, 8'h0);
    wait_done(1, 8'h00, 4'b0010, "sub 05-05");
    issue(3'd3, 2'd0, 2'd0, 8'h80, 8'h01, 9'h0, 8'h0);
    wait_done(1, 8'h7F, 4'b1000, "sub 80-01");
    issue(3'd4, 2'd0, 2'd3, 8'h10, 8'h00, 9'h0, 8'h10);
    wait_done(8, 8'h00, 4'b1010, "mull 10*10");
    issue(3'd5, 2'd0, 2'd0, 8'hFF, 8'hFF, 9'h0, 8'h0);
    wait_done(8, 8'hFE, 4'b0100, "mulh ff*ff");
    issue(3'd4, 2'd0, 2'd0, 8'hFF, 8'hFF, 9'h0, 8'h0);
    wait_done(8, 8'h01, 4'b1000, "mull ff*ff");
    issue(3'd2, 2'd1, 2'd2, 8'h00, 8'h00, 9'h1A5, 8'h0);
    wait_done(1, 8'hA4, 4'b0101, "add swlo+swtop");
    issue(3'd1, 2'd0, 2'd3, 8'h11, 8'h22, 9'h0, 8'h3C);
    wait_done(1, 8'h3C, 4'b0000, "rb imm");
    issue(3'd7, 2'd3, 2'd0, 8'h9A, 8'h22, 9'h0, 8'h0);
    wait_done(1, 8'h9A, 4'b0100, "func7 as ra");

    // start pulses while busy are dropped
    issue(3'd4, 2'd0, 2'd0, 8'h0D, 8'h0B, 9'h0, 8'h0);
    repeat (4) begin
      @(negedge clk);
      bus.func = 3'd2;
      bus.a_in = 8'h01;
      bus.b_in = 8'h01;
      bus.start = 1'b1;
    end
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(3, 8'h8F, 4'b0100, "mull under start");
    issue(3'd2, 2'd0, 2'd0, 8'h12, 8'h34, 9'h0, 8'h0);
    wait_done(1, 8'h46, 4'b0000, "add in done cycle");

    // reset in the middle of a multiply
    issue(3'd4, 2'd0, 2'd0, 8'hFF, 8'hFF, 9'h0, 8'h0);
    repeat (3) @(negedge clk);
    #2 nreset = 1'b0;
    #1;
    chk("midreset busy", 32'(bus.busy), 0);
    chk("midreset done", 32'(bus.done), 0);
    chk("midreset result", 32'(bus.result), 0);
    chk("midreset flags", 32'(bus.flags), 0);
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("no done after reset", 32'(bus.done), 0);
    end
    issue(3'd4, 2'd0, 2'd0, 8'h03, 8'h05, 9'h0, 8'h0);
    wait_done(8, 8'h0F, 4'b0000, "mull 3*5");

    // random traffic, checked every cycle by the model
    repeat (3000) begin
      @(negedge clk);
      bus.start = 1'($urandom_range(0, 1));
      bus.func = 3'($urandom_range(0, 7));
      bus.a_sel = 2'($urandom_range(0, 3));
      bus.b_sel = 2'($urandom_range(0, 3));
      bus.a_in = 8'($urandom);
      bus.b_in = 8'($urandom);
      bus.switches = 9'($urandom);
      bus.immediate = 8'($urandom);
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (12) @(negedge clk);
    check_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the picoMIPS datapath, successor to the single-cycle 4-function ALU. It adds a start/busy/done handshake, keeps operand selection from register, switches or immediate, and generalises width to `N`. It adds an iterative shift-add unsigned multiplier that produces the full 2N-bit product, exposed as low half (MULL) and high half (MULH). Single-cycle functions complete in one clock; multiplies take N clocks. The controller stalls on `busy`.

## Interface
- `N`, 8: datapath width in bits, N ≥ 4.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `nreset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `func`  in  3  0=RA, 1=RB, 2=RADD, 3=RSUB, 4=RMULL, 5=RMULH; 6 and 7 behave as RA.
- `a_sel`, `b_sel`  in  2 each  0=REG, 1=SW_LO (`switches[N-1:0]`), 2=SW_TOP (`switches[N]` replicated N times). For `a_sel`, 3 behaves as REG. For `b_sel`, 3=IMM.
- `a_in`, `b_in`  in  N  register operands.
- `switches`  in  N+1  external switch inputs.
- `immediate`  in  N  instruction immediate.
- `busy`  out  1  operation in progress; `start` is ignored while high.
- `done`  out  1  one-cycle pulse: `result` and `flags` were just updated.
- `result`  out  N  registered result; held until next completion.
- `flags`  out  4  registered {V,N,Z,C}; held with `result`.

## Operation
- Operand muxing is combinational. Selected `a`, `b` and `func` are captured into internal registers on the edge where `start`=1 and `busy`=0 (the "accept edge"). Inputs may change freely afterwards.
- FSM states:
  - IDLE → EXEC when `func` is 0–3 or 6–7.
  - IDLE → MUL when `func` is 4 or 5.
  - EXEC → IDLE unconditionally.
  - MUL → IDLE when the iteration counter reaches N−1.
- EXEC is folded into the accept edge. For single-cycle ops, `result`/`flags` are written on the accept edge, so `done`=1 in the following cycle and the FSM is back in IDLE.
- RA gives `result`=a and RB gives `result`=b. For both, V=C=0.
- RADD gives a+b mod 2^N.
  - V = signed overflow (operand MSBs equal and differ from result MSB).
  - C = carry out of bit N−1.
- RSUB gives a−b mod 2^N.
  - V = signed overflow (operand MSBs differ, result MSB ≠ a MSB).
  - C = borrow, i.e. 1 iff a < b unsigned (picoMIPS inverted-carry convention).
- Multiply datapath: unsigned shift-add using a 2N-bit accumulator P and a ⌈log2 N⌉-bit counter.
  - On accept: P = {N'b0, b}.
  - Each MUL cycle: if P[0], add a to P[2N−1:N] with carry into a 2N+1 intermediate; then shift right 1.
  - After N iterations P = a·b.
- RMULL: `result` = P[N−1:0]; V = (P[2N−1:N] ≠ 0); C=0.
- RMULH: `result` = P[2N−1:N]; V=0; C=0.
- For every func: Z = (`result`==0), N = `result`[N−1].
- `start` while `busy`=1 is ignored; no queuing.
- `func` values 6 and 7 complete as RA. They never hang.

## Timing
- Reset (`nreset`=0, asynchronous, any state, including mid-multiply):
  - FSM → IDLE, counter=0, P=0.
  - `busy`=0, `done`=0, `result`=0, `flags`=0.
  - An in-flight operation is discarded with no `done`.
  - The first accept edge is the first rising edge with `nreset`=1 and `start`=1.
- Single-cycle latency is 1: `done` and new `result` appear in the cycle after the accept edge. `busy` never asserts for these ops.
- Multiply latency is N:
  - `busy`=1 from the cycle after the accept edge through the cycle before `done`, i.e. N−1 cycles.
  - The Nth edge writes `result`/`flags`. In that following cycle `done`=1 and `busy`=0.
- Back-to-back: `start` may be high in the cycle where `done`=1. It is accepted on that edge, giving single-cycle throughput of 1 op/clock.
- `done` is never high for two consecutive cycles from one operation. Consecutive single-cycle ops give consecutive pulses.
- `result`/`flags` change only on completion edges or reset.

## Test plan
- N=8, RADD, a=0x7F, b=0x01 (REG/REG) → next cycle `done`=1, `result`=0x80, flags V=1,N=1,Z=0,C=0. RADD 0xFF+0x01 → 0x00, Z=1, C=1, V=0.
- RSUB 0x00−0x01 → 0xFF, N=1, C=1, V=0. RSUB 0x05−0x05 → 0x00, Z=1, C=0. RSUB 0x80−0x01 → 0x7F, V=1.
- RMULL 0x10×0x10 via `b_sel`=IMM (immediate=0x10) → `busy` high 7 cycles, `done` exactly 8 edges after accept, `result`=0x00, Z=1, V=1. RMULH 0xFF×0xFF → 0xFE, N=1. RMULL same → 0x01, V=1.
- Operand mux: `switches`=0x1A5, `a_sel`=SW_LO, `b_sel`=SW_TOP, RADD → 0xA5+0xFF=0xA4, C=1. Then RB with `b_sel`=IMM, immediate=0x3C → 0x3C.
- Handshake: start RMULL, then pulse `start` with RADD at cycles 2–5 → ignored; single `done` with the multiply result. RADD issued in the `done` cycle → accepted, `done` again next cycle.
- Reset mid-multiply: assert `nreset`=0 asynchronously at cycle 4 → `busy`, `done`, `result`, `flags` all 0 immediately. No `done` after release. A fresh RMULL 3×5 → 0x0F after 8 cycles.
